// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and a
// counter-width helper.
package serial_add_pkg;

  // 2'd3 is unused; the FSM treats it as illegal and returns to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Chunk counter width: $clog2(n), never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ha_cell.sv
// ha_cell: single-bit half adder.
// Ports:
//   a, b : addend bits
//   s    : sum bit   (a ^ b)
//   c    : carry bit (a & b)
module ha_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_ha.sv
// serial_adder_ha: multi-cycle WIDTH-bit adder processing BPC bits per clock,
// LSB first. Each bit of a chunk is a full adder made of two ha_cell
// instances plus an OR; carry_q links successive chunks.
// {cout,sum} = a + b + cin after WIDTH/BPC RUN cycles.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (aborts any operation)
//   start : capture a, b, cin (accepted in IDLE or DONE only)
//   a, b  : WIDTH-bit unsigned operands
//   cin   : carry into bit 0
//   busy  : high while running
//   done  : one-cycle pulse when sum/cout become valid
//   sum   : WIDTH-bit result, held until next accepted start
//   cout  : carry out of the MSB, held with sum
//   ovf   : signed overflow, present only when SERIAL_ADD_OVF_EN is defined
module serial_adder_ha
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N  = WIDTH / BPC;
  localparam int unsigned CW = cnt_w(N);

  if ((BPC == 0) || (WIDTH < 2) || ((WIDTH % BPC) != 0)) begin : g_bad_param
    $error("serial_adder_ha: BPC must divide WIDTH and WIDTH must be >= 2");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, busy_q, done_q, cout_q;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  logic [BPC:0]     chain;
  logic [BPC-1:0]   s0, c0, c1, chunk_s;
  logic [WIDTH-1:0] sum_d;
  logic             accept;

  // One chunk: per bit, two half adders and an OR, carry rippling upward.
  assign chain[0] = carry_q;
  for (genvar i = 0; i < BPC; i++) begin : g_bit
    ha_cell u_ha0 (.a(a_q[i]), .b(b_q[i]),     .s(s0[i]),      .c(c0[i]));
    ha_cell u_ha1 (.a(s0[i]),  .b(chain[i]),   .s(chunk_s[i]), .c(c1[i]));
    assign chain[i+1] = c0[i] | c1[i];
  end

  // New chunk enters from the MSB side so the LSB chunk ends up at bit 0.
  always_comb begin
    sum_d = (sum_q >> BPC) | (WIDTH'(chunk_s) << (WIDTH - BPC));
  end

  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q <= ST_RUN;
        a_q     <= a;
        b_q     <= b;
        carry_q <= cin;
        cnt_q   <= '0;
        sum_q   <= '0;
        cout_q  <= 1'b0;
        busy_q  <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
        ovf_q   <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_IDLE;
          ST_RUN: begin
            a_q     <= a_q >> BPC;
            b_q     <= b_q >> BPC;
            sum_q   <= sum_d;
            carry_q <= chain[BPC];
            cnt_q   <= cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              cout_q  <= chain[BPC];
`ifdef SERIAL_ADD_OVF_EN
              // Last chunk holds the MSB at bit BPC-1.
              ovf_q   <= chain[BPC-1] ^ chain[BPC];
`endif
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
